character_mover: RTL and testbench
==================================

CHARACTER_MOVER -- requirements
Module: character_mover

Interface
REQ-001 SHALL have parameter NUM_CHARS, default 4, number of characters; index 0 is Pac-Man, the rest are ghosts.
REQ-002 SHALL have parameter COORD_W, default 5, tile coordinate width.
REQ-003 SHALL have parameter MAP_W, default 20, map width in tiles (at most 2^COORD_W).
REQ-004 SHALL have parameter MAP_H, default 15, map height in tiles (at most 2^COORD_W).
REQ-005 SHALL have parameter WALL_CODE, default 3'd1, sprite code that blocks movement.
REQ-006 SHALL have parameter INIT_X, default all-zero packed NUM_CHARS*COORD_W, start columns.
REQ-007 SHALL have parameter INIT_Y, default all-zero packed NUM_CHARS*COORD_W, start rows.
REQ-008 SHALL have ports: clock_50 in 1 system clock; reset in 1 synchronous active-high reset.
REQ-009 SHALL have ports: en in 1 global enable; tick in 1 single-cycle move strobe.
REQ-010 SHALL have ports: dir_in in 2*NUM_CHARS per-character direction (00 up, 01 down, 10 left, 11 right); move_en in NUM_CHARS per-character move request.
REQ-011 SHALL have ports: map_x out COORD_W; map_y out COORD_W; map_rd_req out 1; map_rd_valid in 1; sprite_data in 3.
REQ-012 SHALL have ports: char_x out NUM_CHARS*COORD_W; char_y out NUM_CHARS*COORD_W; busy out 1; done out 1; collision out NUM_CHARS; overrun out 1.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT, COMMIT, CHECK.
REQ-014 IDLE: on tick=1 with en=1, SHALL latch dir_in and move_en, clear idx to 0, and go to ISSUE on the next cycle; busy SHALL be 1 in every non-IDLE state.
REQ-015 ISSUE: SHALL compute target tile for character idx from latched dir; if move_en[idx]=0, target SHALL equal the current position.
REQ-016 Wrap: left at x=0 SHALL give MAP_W-1; right at MAP_W-1 SHALL give 0; up at y=0 SHALL give MAP_H-1; down at MAP_H-1 SHALL give 0.
REQ-017 ISSUE: SHALL drive map_x/map_y with the target, pulse map_rd_req for exactly one cycle, then go to WAIT.
REQ-018 WAIT: map_x/map_y SHALL be held stable until map_rd_valid=1, with no timeout.
REQ-019 WAIT: on map_rd_valid=1, SHALL capture sprite_data and go to COMMIT.
REQ-020 COMMIT: SHALL update character idx to the target iff sprite!=WALL_CODE, otherwise keep the current position.
REQ-021 COMMIT: if idx==NUM_CHARS-1, SHALL go to CHECK; else SHALL increment idx and go to ISSUE.
REQ-022 CHECK: collision[i] SHALL be registered as 1 iff i>0 and character i position equals character 0 position; collision[0] SHALL be 0.
REQ-023 CHECK: SHALL pulse done for one cycle and return to IDLE.
REQ-024 Ghost moves SHALL NOT be blocked by other characters, only by walls.
REQ-025 Ticks arriving while busy=1 SHALL be ignored and SHALL set sticky overrun=1, cleared only by reset.
REQ-026 en=0 in IDLE SHALL ignore tick without setting overrun; en=0 mid-pass SHALL NOT abort the pass.
REQ-027 map_rd_valid outside WAIT SHALL be ignored.
REQ-028 Tick and map_rd_valid arriving in the same cycle SHALL be processed independently per REQ-019 and REQ-025.
REQ-029 Latency with zero-wait map: tick to done SHALL be 1 + 3*NUM_CHARS + 1 cycles (14 for NUM_CHARS=4).

Reset
REQ-030 On reset=1 at a clock edge, SHALL force state IDLE, idx 0, positions to INIT_X/INIT_Y, and collision, done, busy, map_rd_req, overrun all to 0.
REQ-031 Reset mid-pass SHALL discard the pass, and no done pulse SHALL follow.
REQ-032 map_x/map_y SHALL reset to 0.
REQ-033 Reset SHALL take priority over tick.

Structure
REQ-034 Direction encodings, WALL_CODE and the FSM state enum SHALL live in shared package pacman_pkg, reused by display_controller and map_controller.
REQ-035 Target/wrap computation SHALL be one combinational sub-module tile_stepper (inputs x, y, dir, move_en; outputs tx, ty; parameters MAP_W, MAP_H, COORD_W).
REQ-036 Position storage SHALL be flat registers indexed by idx, with no RAM.

Verification
REQ-037 Free path: char0 at (5,5), dir right, map returns 0 -> char0=(6,5), done 14 cycles after tick.
REQ-038 Wall: char1 at (3,3), dir up, sprite at (3,2)=WALL_CODE -> char1 stays (3,3), others move normally.
REQ-039 Wrap: char2 at (0,7) left -> map_x=19, map_y=7 requested, char2=(19,7); char3 at (4,14) down -> (4,0).
REQ-040 Collision: char0 moves into tile where char2 ends -> collision=4'b0100 with done; no overlap -> 0.
REQ-041 Overrun/stall: map_rd_valid delayed 10 cycles with tick re-pulsed meanwhile -> map_x/map_y stable, single pass, overrun=1.
REQ-042 Reset mid-pass in WAIT -> positions=INIT, busy=0, no done pulse.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared maze-game types: movement directions, wall sprite code and mover FSM states.
package pacman_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  localparam logic [2:0] WALL_CODE_DEFAULT = 3'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_COMMIT,
    ST_CHECK
  } mover_state_t;

endpackage

// File: rtl/tile_stepper.sv
// One-tile step of a character in a direction, wrapping toroidally at the map edges.
// Purely combinational; a disabled move returns the current tile.
module tile_stepper
  import pacman_pkg::*;
#(
  parameter int MAP_W   = 20,
  parameter int MAP_H   = 15,
  parameter int COORD_W = 5
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [1:0]         dir,
  input  logic               move_en,
  output logic [COORD_W-1:0] tx,
  output logic [COORD_W-1:0] ty
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(MAP_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(MAP_H - 1);

  always_comb begin
    tx = x;
    ty = y;
    if (move_en) begin
      case (dir_t'(dir))
        DIR_UP:    ty = (y == '0)    ? Y_MAX : y - 1'b1;
        DIR_DOWN:  ty = (y == Y_MAX) ? '0    : y + 1'b1;
        DIR_LEFT:  tx = (x == '0)    ? X_MAX : x - 1'b1;
        DIR_RIGHT: tx = (x == X_MAX) ? '0    : x + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/character_mover.sv
// Steps every character one tile per tick, consulting the map for walls one character at a time.
// Tick-to-done is 2 + NUM_CHARS*(3 + map wait) cycles; the map may stall WAIT indefinitely.
module character_mover
  import pacman_pkg::*;
#(
  parameter int                           NUM_CHARS = 4,
  parameter int                           COORD_W   = 5,
  parameter int                           MAP_W     = 20,
  parameter int                           MAP_H     = 15,
  parameter logic [2:0]                   WALL_CODE = WALL_CODE_DEFAULT,
  parameter logic [NUM_CHARS*COORD_W-1:0] INIT_X    = '0,
  parameter logic [NUM_CHARS*COORD_W-1:0] INIT_Y    = '0
) (
  input  logic                           clock_50,
  input  logic                           reset,
  input  logic                           en,
  input  logic                           tick,
  input  logic [2*NUM_CHARS-1:0]         dir_in,
  input  logic [NUM_CHARS-1:0]           move_en,
  output logic [COORD_W-1:0]             map_x,
  output logic [COORD_W-1:0]             map_y,
  output logic                           map_rd_req,
  input  logic                           map_rd_valid,
  input  logic [2:0]                     sprite_data,
  output logic [NUM_CHARS*COORD_W-1:0]   char_x,
  output logic [NUM_CHARS*COORD_W-1:0]   char_y,
  output logic                           busy,
  output logic                           done,
  output logic [NUM_CHARS-1:0]           collision,
  output logic                           overrun
);

  localparam int              IDX_W    = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHARS - 1);

  mover_state_t           r_state, w_next;
  logic [IDX_W-1:0]       r_idx;
  logic [2*NUM_CHARS-1:0] r_dir;
  logic [NUM_CHARS-1:0]   r_move_en;
  logic [COORD_W-1:0]     r_pos_x [NUM_CHARS];
  logic [COORD_W-1:0]     r_pos_y [NUM_CHARS];
  logic [COORD_W-1:0]     r_map_x, r_map_y;
  logic [2:0]             r_sprite;
  logic                   r_done, r_overrun;
  logic [NUM_CHARS-1:0]   r_coll;

  logic [COORD_W-1:0]     w_tx, w_ty;
  logic [1:0]             w_dir;
  logic                   w_busy, w_start;

  assign w_busy  = (r_state != ST_IDLE);
  assign w_start = (r_state == ST_IDLE) && tick && en;
  assign w_dir   = r_dir[{r_idx, 1'b0} +: 2];

  tile_stepper #(
    .MAP_W  (MAP_W),
    .MAP_H  (MAP_H),
    .COORD_W(COORD_W)
  ) u_stepper (
    .x      (r_pos_x[r_idx]),
    .y      (r_pos_y[r_idx]),
    .dir    (w_dir),
    .move_en(r_move_en[r_idx]),
    .tx     (w_tx),
    .ty     (w_ty)
  );

  always_ff @(posedge clock_50) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_start) w_next = ST_ISSUE;
      ST_ISSUE:  w_next = ST_WAIT;
      ST_WAIT:   if (map_rd_valid) w_next = ST_COMMIT;
      ST_COMMIT: w_next = (r_idx == LAST_IDX) ? ST_CHECK : ST_ISSUE;
      ST_CHECK:  w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      r_idx     <= '0;
      r_dir     <= '0;
      r_move_en <= '0;
      r_map_x   <= '0;
      r_map_y   <= '0;
      r_sprite  <= '0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_coll    <= '0;
      for (int i = 0; i < NUM_CHARS; i++) begin
        r_pos_x[i] <= INIT_X[i*COORD_W +: COORD_W];
        r_pos_y[i] <= INIT_Y[i*COORD_W +: COORD_W];
      end
    end else begin
      r_done <= 1'b0;
      if (tick && w_busy) r_overrun <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_dir     <= dir_in;
            r_move_en <= move_en;
            r_idx     <= '0;
          end
        end
        // The held address doubles as the committed target.
        ST_ISSUE: begin
          r_map_x <= w_tx;
          r_map_y <= w_ty;
        end
        ST_WAIT: begin
          if (map_rd_valid) r_sprite <= sprite_data;
        end
        ST_COMMIT: begin
          if (r_sprite != WALL_CODE) begin
            r_pos_x[r_idx] <= r_map_x;
            r_pos_y[r_idx] <= r_map_y;
          end
          if (r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
        end
        ST_CHECK: begin
          r_done <= 1'b1;
          for (int i = 0; i < NUM_CHARS; i++) begin
            r_coll[i] <= (i != 0) && (r_pos_x[i] == r_pos_x[0]) && (r_pos_y[i] == r_pos_y[0]);
          end
        end
        default: ;
      endcase
    end
  end

  // Address is live from the stepper during ISSUE so a one-cycle map can answer in WAIT.
  assign map_x      = (r_state == ST_ISSUE) ? w_tx : r_map_x;
  assign map_y      = (r_state == ST_ISSUE) ? w_ty : r_map_y;
  assign map_rd_req = (r_state == ST_ISSUE);
  assign busy       = w_busy;
  assign done       = r_done;
  assign collision  = r_coll;
  assign overrun    = r_overrun;

  for (genvar g = 0; g < NUM_CHARS; g++) begin : g_pos
    assign char_x[g*COORD_W +: COORD_W] = r_pos_x[g];
    assign char_y[g*COORD_W +: COORD_W] = r_pos_y[g];
  end

endmodule

// File: tb/tb_character_mover.sv
// Bench for character_mover: directed table of passes, stall/overrun and reset cases, random passes vs a modular-arithmetic model.
module tb_character_mover;
  import pacman_pkg::*;

  localparam int N = 4, CW = 5, MW = 20, MH = 15;
  localparam logic [N*CW-1:0] IX = {5'd4, 5'd0, 5'd3, 5'd5};
  localparam logic [N*CW-1:0] IY = {5'd14, 5'd7, 5'd3, 5'd5};

  logic clk = 1'b0;
  logic reset, en, tick, map_rd_valid, map_rd_req, busy, done, overrun;
  logic [2*N-1:0]  dir_in;
  logic [N-1:0]    move_en, collision;
  logic [CW-1:0]   map_x, map_y;
  logic [2:0]      sprite_data;
  logic [N*CW-1:0] char_x, char_y;

  always #5 clk = ~clk;

  character_mover #(
    .NUM_CHARS(N), .COORD_W(CW), .MAP_W(MW), .MAP_H(MH),
    .WALL_CODE(WALL_CODE_DEFAULT), .INIT_X(IX), .INIT_Y(IY)
  ) dut (
    .clock_50(clk), .reset(reset), .en(en), .tick(tick),
    .dir_in(dir_in), .move_en(move_en),
    .map_x(map_x), .map_y(map_y), .map_rd_req(map_rd_req),
    .map_rd_valid(map_rd_valid), .sprite_data(sprite_data),
    .char_x(char_x), .char_y(char_y), .busy(busy), .done(done),
    .collision(collision), .overrun(overrun)
  );

  logic [2:0] map_mem [MW][MH];
  int         rd_delay = 0;
  int         stab_err;
  logic [9:0] reqs[$];
  int         total = 0, bad = 0;
  int         mx[N], my[N];

  typedef struct packed {
    logic [7:0]  dir;
    logic [3:0]  men;
    logic [4:0]  wx, wy;
    logic [19:0] ex, ey;
    logic [3:0]  coll;
  } vec_t;

  // Map responder: answers each request after rd_delay extra cycles and watches the address hold.
  initial begin
    logic [CW-1:0] qx, qy;
    map_rd_valid = 1'b0;
    sprite_data  = 3'd0;
    stab_err     = 0;
    forever begin
      @(negedge clk);
      if (map_rd_req) begin
        qx = map_x;
        qy = map_y;
        reqs.push_back({qx, qy});
        repeat (rd_delay + 1) begin
          @(posedge clk); #1;
          if (map_x !== qx || map_y !== qy || map_rd_req !== 1'b0) stab_err++;
        end
        map_rd_valid = 1'b1;
        sprite_data  = (qx < MW && qy < MH) ? map_mem[qx][qy] : 3'd0;
        @(posedge clk); #1;
        map_rd_valid = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_map();
    for (int x = 0; x < MW; x++)
      for (int y = 0; y < MH; y++) map_mem[x][y] = 3'd0;
  endtask

  task automatic random_map();
    for (int x = 0; x < MW; x++)
      for (int y = 0; y < MH; y++)
        map_mem[x][y] = ($urandom_range(0, 3) == 0) ? WALL_CODE_DEFAULT : 3'($urandom_range(2, 7));
  endtask

  task automatic model_pass(input logic [7:0] d, input logic [3:0] m);
    for (int i = 0; i < N; i++) begin
      int tx = mx[i], ty = my[i];
      if (m[i]) begin
        case (d[2*i +: 2])
          2'b00: ty = (ty + MH - 1) % MH;
          2'b01: ty = (ty + 1) % MH;
          2'b10: tx = (tx + MW - 1) % MW;
          default: tx = (tx + 1) % MW;
        endcase
      end
      if (map_mem[tx][ty] != WALL_CODE_DEFAULT) begin
        mx[i] = tx;
        my[i] = ty;
      end
    end
  endtask

  function automatic logic [19:0] pack_pos(input bit is_y);
    logic [19:0] r = '0;
    for (int i = 0; i < N; i++) r[i*CW +: CW] = CW'(is_y ? my[i] : mx[i]);
    return r;
  endfunction

  function automatic logic [3:0] model_coll();
    logic [3:0] c = '0;
    for (int i = 1; i < N; i++) c[i] = (mx[i] == mx[0]) && (my[i] == my[0]);
    return c;
  endfunction

  // Starts a pass and scrambles inputs until done; optionally re-pulses tick while busy.
  task automatic do_pass(input logic [7:0] d, input logic [3:0] m, input int dly,
                         input bit retick, output int lat);
    rd_delay = dly;
    dir_in = d; move_en = m; en = 1'b1; tick = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      tick    = retick && !done && (lat % 3 == 0);
      dir_in  = 8'($urandom);
      move_en = 4'($urandom);
      en      = 1'($urandom);
    end while (!done && lat < 400);
    tick = 1'b0; en = 1'b1;
    if (!done) begin
      total++; bad++;
      $display("FAIL pass_timeout: got no done after %0d cycles", lat);
    end
  endtask

  task automatic after_pass();
    chk("busy_at_done", busy, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
  endtask

  vec_t vecs[6];
  int   lat, s0, extra;

  initial begin
    vecs[0] = '{8'b01100011, 4'b1111, 5'd3, 5'd2,
                {5'd4, 5'd19, 5'd3, 5'd6}, {5'd0, 5'd7, 5'd3, 5'd5}, 4'b0000};
    vecs[1] = '{8'b11000110, 4'b1110, 5'd10, 5'd10,
                {5'd5, 5'd19, 5'd3, 5'd6}, {5'd0, 5'd6, 5'd4, 5'd5}, 4'b0000};
    vecs[2] = '{8'b00000110, 4'b1111, 5'd5, 5'd14,
                {5'd5, 5'd19, 5'd3, 5'd5}, {5'd0, 5'd5, 5'd5, 5'd5}, 4'b0000};
    vecs[3] = '{8'b00110010, 4'b0101, 5'd10, 5'd10,
                {5'd5, 5'd0, 5'd3, 5'd4}, {5'd0, 5'd5, 5'd5, 5'd5}, 4'b0000};
    vecs[4] = '{8'b00110010, 4'b0101, 5'd10, 5'd10,
                {5'd5, 5'd1, 5'd3, 5'd3}, {5'd0, 5'd5, 5'd5, 5'd5}, 4'b0010};
    vecs[5] = '{8'b00110010, 4'b0101, 5'd10, 5'd10,
                {5'd5, 5'd2, 5'd3, 5'd2}, {5'd0, 5'd5, 5'd5, 5'd5}, 4'b0100};

    reset = 1'b1; en = 1'b0; tick = 1'b0; dir_in = '0; move_en = '0;
    clear_map();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_char_x", char_x, IX);
    chk("rst_char_y", char_y, IY);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_collision", collision, 0);
    chk("rst_map_xy", {map_x, map_y}, 0);
    chk("rst_rd_req", map_rd_req, 0);

    // Tick with enable low in IDLE is ignored and is not an overrun.
    en = 1'b0; tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0; en = 1'b1;
    chk("en0_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("en0_overrun", overrun, 0);

    for (int e = 0; e < 6; e++) begin
      int base;
      clear_map();
      map_mem[vecs[e].wx][vecs[e].wy] = WALL_CODE_DEFAULT;
      base = reqs.size();
      do_pass(vecs[e].dir, vecs[e].men, 0, 1'b0, lat);
      chk($sformatf("vec%0d_latency", e), lat, 14);
      chk($sformatf("vec%0d_char_x", e), char_x, vecs[e].ex);
      chk($sformatf("vec%0d_char_y", e), char_y, vecs[e].ey);
      chk($sformatf("vec%0d_collision", e), collision, vecs[e].coll);
      chk($sformatf("vec%0d_reqs", e), reqs.size() - base, 4);
      if (e == 0 && reqs.size() >= base + 4) begin
        chk("wrap_left_req", reqs[base+2], {5'd19, 5'd7});
        chk("wrap_down_req", reqs[base+3], {5'd4, 5'd0});
      end
      after_pass();
    end
    chk("table_overrun", overrun, 0);

    for (int i = 0; i < N; i++) begin
      mx[i] = int'(vecs[5].ex[i*CW +: CW]);
      my[i] = int'(vecs[5].ey[i*CW +: CW]);
    end

    // Slow map with tick re-pulsed while stalled: one pass only, address held, overrun latched.
    random_map();
    s0 = stab_err;
    model_pass(8'b11100100, 4'b1111);
    do_pass(8'b11100100, 4'b1111, 10, 1'b1, lat);
    chk("stall_latency", lat, 2 + 4 * 13);
    chk("stall_char_x", char_x, pack_pos(0));
    chk("stall_char_y", char_y, pack_pos(1));
    chk("stall_addr_hold", stab_err - s0, 0);
    extra = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    chk("stall_single_pass", extra, 0);
    chk("stall_overrun", overrun, 1);

    for (int k = 0; k < 20; k++) begin
      logic [7:0] d;
      logic [3:0] m;
      int dly;
      bit rt;
      random_map();
      d = 8'($urandom); m = 4'($urandom);
      dly = $urandom_range(0, 3); rt = 1'($urandom);
      model_pass(d, m);
      do_pass(d, m, dly, rt, lat);
      chk($sformatf("rnd%0d_latency", k), lat, 2 + 4 * (3 + dly));
      chk($sformatf("rnd%0d_char_x", k), char_x, pack_pos(0));
      chk($sformatf("rnd%0d_char_y", k), char_y, pack_pos(1));
      chk($sformatf("rnd%0d_collision", k), collision, model_coll());
      chk($sformatf("rnd%0d_overrun", k), overrun, 1);
      after_pass();
    end
    chk("addr_hold_all", stab_err, 0);

    // Reset while stalled in WAIT drops the pass without a done.
    rd_delay = 10; en = 1'b1; tick = 1'b1; dir_in = 8'hFF; move_en = 4'hF;
    @(posedge clk); #1;
    tick = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midpass_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_char_x", char_x, IX);
    chk("midrst_char_y", char_y, IY);
    chk("midrst_busy", busy, 0);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_map_xy", {map_x, map_y}, 0);
    extra = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    chk("midrst_no_done", extra, 0);
    chk("midrst_pos_kept", char_x, IX);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
